// File: rtl/dm_arb_defs.sv
// Shared definitions for the data-memory arbiter: state/owner encodings and the
// latched transaction record.
package dm_arb_defs;
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BUSY_CPU = 2'd1,
    ST_BUSY_DMA = 2'd2
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

  localparam logic [3:0] BE_NONE = 4'b0000;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byteen;
  } xact_t;
endpackage

// File: rtl/dm_arbiter_if.sv
// Bundle of requester and memory-side signals around dm_arbiter.
// slave = arbiter view, master = the surrounding requesters and memory.
interface dm_arbiter_if;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_byteen;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;
  logic        cpu_done;

  logic        dma_req;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic [3:0]  dma_byteen;
  logic        dma_ack;
  logic [31:0] dma_rdata;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byteen;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_addr, cpu_wdata, cpu_byteen,
    input  dma_req, dma_addr, dma_wdata, dma_byteen,
    input  mem_ready, mem_rdata,
    output cpu_stall, cpu_rdata, cpu_done,
    output dma_ack, dma_rdata,
    output mem_req, mem_addr, mem_wdata, mem_byteen
  );

  modport master (
    output cpu_req, cpu_addr, cpu_wdata, cpu_byteen,
    output dma_req, dma_addr, dma_wdata, dma_byteen,
    output mem_ready, mem_rdata,
    input  cpu_stall, cpu_rdata, cpu_done,
    input  dma_ack, dma_rdata,
    input  mem_req, mem_addr, mem_wdata, mem_byteen
  );
endinterface

// File: rtl/dm_arb_wait_counter.sv
// Saturating count of cycles a DMA request has been passed over.
// sat_o tells the arbiter the DMA must win the next IDLE arbitration.
module dm_arb_wait_counter
  import dm_arb_defs::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);
  localparam int W = $clog2(MAX_WAIT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign sat_o = (cnt_q == W'(MAX_WAIT));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)               cnt_d = '0;
    else if (inc_i && !sat_o) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/dm_arbiter.sv
// Two-master data-memory arbiter: CPU has fixed priority, DMA is guaranteed a
// grant after MAX_WAIT lost cycles. Serialises accesses with one IDLE gap.
module dm_arbiter
  import dm_arb_defs::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic         clk,
  input  logic         reset,
  dm_arbiter_if.slave  bus
);
  state_e      state_q;
  xact_t       fld_q;
  xact_t       cpu_x, dma_x;
  logic [31:0] cpu_rdata_q, dma_rdata_q;
  logic        cpu_done_q, dma_ack_q, mem_req_q;
  logic        sat, idle, dma_win, cpu_win, wait_inc;
  owner_e      win_own;

  assign cpu_x = '{bus.cpu_addr, bus.cpu_wdata, bus.cpu_byteen};
  assign dma_x = '{bus.dma_addr, bus.dma_wdata, bus.dma_byteen};

  assign idle    = (state_q == ST_IDLE);
  assign dma_win = idle && bus.dma_req && (sat || !bus.cpu_req);
  assign cpu_win = idle && bus.cpu_req && !(bus.dma_req && sat);
  assign win_own = dma_win ? OWN_DMA : OWN_CPU;
  // A pending DMA ages whenever it is neither winning nor already on the bus.
  assign wait_inc = bus.dma_req && !dma_win && (state_q != ST_BUSY_DMA);

  dm_arb_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_wait (
    .clk   (clk),
    .reset (reset),
    .inc_i (wait_inc),
    .clr_i (dma_win),
    .sat_o (sat)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      fld_q       <= '{32'd0, 32'd0, BE_NONE};
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      cpu_done_q  <= 1'b0;
      dma_ack_q   <= 1'b0;
    end else begin
      cpu_done_q <= 1'b0;
      dma_ack_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (cpu_win || dma_win) begin
            fld_q     <= (win_own == OWN_DMA) ? dma_x : cpu_x;
            mem_req_q <= 1'b1;
            state_q   <= (win_own == OWN_DMA) ? ST_BUSY_DMA : ST_BUSY_CPU;
          end
        end
        ST_BUSY_CPU: begin
          if (bus.mem_ready) begin
            cpu_rdata_q <= bus.mem_rdata;
            cpu_done_q  <= 1'b1;
            mem_req_q   <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        ST_BUSY_DMA: begin
          if (bus.mem_ready) begin
            dma_rdata_q <= bus.mem_rdata;
            dma_ack_q   <= 1'b1;
            mem_req_q   <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = fld_q.addr;
  assign bus.mem_wdata  = fld_q.wdata;
  assign bus.mem_byteen = fld_q.byteen;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.cpu_done   = cpu_done_q;
  assign bus.dma_rdata  = dma_rdata_q;
  assign bus.dma_ack    = dma_ack_q;
  assign bus.cpu_stall  = bus.cpu_req & ~cpu_done_q;
endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios then randomized traffic, all checked
// against a transaction-level reference model of the arbitration rules.
module tb_dm_arbiter;
  localparam int MAXW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dm_arbiter_if bus();
  dm_arbiter #(.MAX_WAIT(MAXW)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_chk = 0, n_pass = 0;
  int stall_cnt = 0;

  // Reference model: who owns the bus (0 none, 1 cpu, 2 dma), DMA age, expected regs.
  int          m_own = 0, m_wait = 0;
  logic [31:0] m_addr = 0, m_wdata = 0, m_crd = 0, m_drd = 0;
  logic [3:0]  m_be = 0;
  logic        m_done = 0, m_ack = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic take(input logic [31:0] a, input logic [31:0] w, input logic [3:0] be, input int who);
    m_addr = a; m_wdata = w; m_be = be; m_own = who;
  endtask

  // One clock: check stall, predict the edge, advance, check all registered outputs.
  task automatic step();
    #1;
    chk("cpu_stall", bus.cpu_stall, bus.cpu_req & ~m_done);
    stall_cnt += int'(bus.cpu_stall);
    m_done = 1'b0;
    m_ack  = 1'b0;
    if (reset) begin
      m_own = 0; m_wait = 0; m_addr = 0; m_wdata = 0; m_be = 0; m_crd = 0; m_drd = 0;
    end else if (m_own == 0) begin
      if (bus.dma_req && m_wait == MAXW) begin
        take(bus.dma_addr, bus.dma_wdata, bus.dma_byteen, 2); m_wait = 0;
      end else if (bus.cpu_req) begin
        take(bus.cpu_addr, bus.cpu_wdata, bus.cpu_byteen, 1);
        if (bus.dma_req && m_wait < MAXW) m_wait++;
      end else if (bus.dma_req) begin
        take(bus.dma_addr, bus.dma_wdata, bus.dma_byteen, 2); m_wait = 0;
      end
    end else if (m_own == 1) begin
      if (bus.dma_req && m_wait < MAXW) m_wait++;
      if (bus.mem_ready) begin m_crd = bus.mem_rdata; m_done = 1'b1; m_own = 0; end
    end else if (bus.mem_ready) begin
      m_drd = bus.mem_rdata; m_ack = 1'b1; m_own = 0;
    end
    @(posedge clk);
    #1;
    chk("mem_req",    bus.mem_req,    m_own != 0);
    chk("mem_addr",   bus.mem_addr,   m_addr);
    chk("mem_wdata",  bus.mem_wdata,  m_wdata);
    chk("mem_byteen", bus.mem_byteen, m_be);
    chk("cpu_done",   bus.cpu_done,   m_done);
    chk("dma_ack",    bus.dma_ack,    m_ack);
    chk("cpu_rdata",  bus.cpu_rdata,  m_crd);
    chk("dma_rdata",  bus.dma_rdata,  m_drd);
  endtask

  // Requesters hold their request until the model says it completed.
  task automatic drive_rand();
    if (!bus.cpu_req || m_done) begin
      bus.cpu_req    = 1'($urandom_range(0, 1));
      bus.cpu_addr   = $urandom;
      bus.cpu_wdata  = $urandom;
      bus.cpu_byteen = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0;
    end
    if (!bus.dma_req || m_ack) begin
      bus.dma_req    = ($urandom_range(0, 2) == 0);
      bus.dma_addr   = $urandom;
      bus.dma_wdata  = $urandom;
      bus.dma_byteen = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0;
    end
    bus.mem_ready = ($urandom_range(0, 2) == 0);
    bus.mem_rdata = $urandom;
    reset         = ($urandom_range(0, 199) == 0);
  endtask

  initial begin
    int idx, ndone;
    reset = 1'b1;
    bus.cpu_req = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0; bus.cpu_byteen = 0;
    bus.dma_req = 0; bus.dma_addr = 0; bus.dma_wdata = 0; bus.dma_byteen = 0;
    bus.mem_ready = 0; bus.mem_rdata = 0;
    step(); step();
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 0);
    chk("rst_dma_ack", bus.dma_ack, 0);
    reset = 1'b0;

    // CPU read alone, mem_ready one cycle after mem_req rises
    bus.cpu_req = 1; bus.cpu_addr = 32'h0000_1004; bus.cpu_byteen = 4'b0;
    stall_cnt = 0;
    step();
    chk("cpu_rd_mem_req", bus.mem_req, 1);
    chk("cpu_rd_addr", bus.mem_addr, 32'h0000_1004);
    step();
    bus.mem_ready = 1; bus.mem_rdata = 32'hDEAD_BEEF;
    step();
    chk("cpu_rd_done", bus.cpu_done, 1);
    chk("cpu_rd_data", bus.cpu_rdata, 32'hDEAD_BEEF);
    bus.cpu_req = 0; bus.mem_ready = 0;
    step();
    chk("cpu_rd_stall_cycles", stall_cnt, 3);

    // DMA write alone, mem_ready immediate
    bus.dma_req = 1; bus.dma_addr = 32'h0000_2000; bus.dma_byteen = 4'b0011;
    bus.dma_wdata = 32'h1234_1234; bus.mem_ready = 1;
    step();
    chk("dma_wr_byteen", bus.mem_byteen, 4'b0011);
    chk("dma_wr_wdata", bus.mem_wdata, 32'h1234_1234);
    step();
    chk("dma_wr_ack", bus.dma_ack, 1);
    chk("dma_wr_req_low", bus.mem_req, 0);
    bus.dma_req = 0; bus.mem_ready = 0;
    step();

    // Simultaneous requests: CPU first, one idle gap, then DMA
    bus.cpu_req = 1; bus.cpu_addr = 32'hA000_0000; bus.cpu_byteen = 4'b0;
    bus.dma_req = 1; bus.dma_addr = 32'hB000_0000; bus.dma_byteen = 4'b0;
    bus.mem_ready = 1;
    step();
    chk("sim_first_cpu", bus.mem_addr, 32'hA000_0000);
    step();
    chk("sim_gap_req", bus.mem_req, 0);
    bus.cpu_req = 0;
    step();
    chk("sim_second_dma", bus.mem_addr, 32'hB000_0000);
    chk("sim_second_req", bus.mem_req, 1);
    step();
    chk("sim_dma_ack", bus.dma_ack, 1);
    bus.dma_req = 0; bus.mem_ready = 0;
    step();

    // Starvation guard: CPU hammering, DMA waits; counter starts from reset
    reset = 1; step(); reset = 0;
    bus.cpu_req = 1; bus.dma_req = 1; bus.mem_ready = 1;
    idx = 0; ndone = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      ndone += int'(bus.cpu_done);
      if (bus.mem_req && bus.mem_addr == 32'hB000_0000) begin idx = i; break; end
    end
    chk("starve_grant_cycle", idx, 5);
    chk("starve_cpu_done", ndone, 2);
    step();
    chk("starve_dma_ack", bus.dma_ack, 1);
    step();
    chk("starve_wait_cleared", bus.mem_addr, 32'hA000_0000);
    bus.dma_req = 0;
    step();
    bus.cpu_req = 0; bus.mem_ready = 0;
    step();

    // Reset during BUSY_CPU one cycle before mem_ready
    bus.cpu_req = 1; bus.cpu_addr = 32'hC000_0004;
    step(); step();
    reset = 1;
    step();
    chk("rst_busy_req", bus.mem_req, 0);
    chk("rst_busy_done", bus.cpu_done, 0);
    chk("rst_busy_rdata", bus.cpu_rdata, 0);
    reset = 0; bus.cpu_req = 0; bus.mem_ready = 1;
    step();
    chk("rst_busy_no_pulse", bus.cpu_done, 0);

    // mem_ready while idle is ignored
    for (int i = 0; i < 3; i++) begin
      bus.mem_rdata = $urandom;
      step();
      chk("idle_ready_done", bus.cpu_done, 0);
      chk("idle_ready_ack", bus.dma_ack, 0);
    end
    chk("idle_ready_crd", bus.cpu_rdata, 0);
    chk("idle_ready_drd", bus.dma_rdata, 0);
    bus.mem_ready = 0;

    for (int i = 0; i < 3000; i++) begin
      drive_rand();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
